uart_cfg: RTL and testbench

// Parametrised full-duplex UART, successor to the fixed 8N1 UART in the wireless link.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_if.sv | 29 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_cfg.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART shared types: parity mode and FSM state encodings.
// Helper for computing the parity bit of a word.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // x is the XOR of the data bits; result is the parity bit to send
  function automatic logic par_bit(parity_t p, logic x);
    return x ^ (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_if.sv
// UART pin and stream bundle.
// master = user/line side, slave = the UART itself.
interface uart_if #(
  parameter int DATA = 8
);

  logic [DATA-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            tx;
  logic            rx;
  logic [DATA-1:0] rx_data;
  logic            rx_valid;
  logic            rx_frame_err;
  logic            rx_parity_err;

  modport master (
    output tx_data, tx_valid, rx,
    input  tx_ready, tx, rx_data,
    input  rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid, rx,
    output tx_ready, tx, rx_data,
    output rx_valid, rx_frame_err, rx_parity_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clocks since the last clear.
// half_o on the HALF-th clock, full_o on the CYCLES-th clock.
module uart_bit_timer #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam int W    = $clog2(CYCLES + 1);
  localparam int HALF = CYCLES / 2;

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise advance
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i) cnt_d = '0;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign half_o = (cnt_q == W'(HALF - 1));
  assign full_o = (cnt_q == W'(CYCLES - 1));

endmodule

// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: DATA bits, none/even/odd parity,
// 1-2 stop bits, synchronised mid-bit sampled receiver.
module uart_cfg
  import uart_pkg::*;
#(
  parameter int      CLOCK  = 50000000,
  parameter int      BAUD   = 9600,
  parameter int      DATA   = 8,
  parameter parity_t PARITY = PAR_NONE,
  parameter int      STOP   = 1
) (
  input logic  clk,
  input logic  rst,
  uart_if.slave bus
);

  localparam int CYCLES = CLOCK / BAUD;
  localparam int IW     = $clog2(DATA + 1);

  if (CYCLES < 4 || DATA < 5 || DATA > 9 ||
      STOP < 1 || STOP > 2) begin : g_bad_cfg
    $error("uart_cfg: illegal CYCLES/DATA/STOP");
  end

  // ---------------- transmitter ----------------
  tx_state_t       tx_st_q, tx_st_d;
  logic [DATA-1:0] tx_sh_q, tx_sh_d;
  logic [IW-1:0]   tx_idx_q, tx_idx_d;
  logic            tx_par_q, tx_par_d;
  logic            tx_q, tx_d;
  logic            tx_clr, tx_full, tx_half_unused;

  uart_bit_timer #(.CYCLES(CYCLES)) u_tx_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tx_clr),
    .half_o (tx_half_unused),
    .full_o (tx_full)
  );

  // TX sequencing; the line level is registered for a glitch-free pin
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
    tx_par_d = tx_par_q;
    tx_d     = tx_q;
    tx_clr   = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_valid) begin
          tx_st_d  = TX_START;
          tx_sh_d  = bus.tx_data;
          tx_par_d = par_bit(PARITY, ^bus.tx_data);
          tx_d     = 1'b0;
          tx_clr   = 1'b1;
        end
      end
      TX_START: begin
        if (tx_full) begin
          tx_st_d  = TX_DATA;
          tx_d     = tx_sh_q[0];
          tx_idx_d = '0;
          tx_clr   = 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_full) begin
          tx_clr = 1'b1;
          if (tx_idx_q == IW'(DATA - 1)) begin
            tx_idx_d = '0;
            if (PARITY == PAR_NONE) begin
              tx_st_d = TX_STOP;
              tx_d    = 1'b1;
            end else begin
              tx_st_d = TX_PAR;
              tx_d    = tx_par_q;
            end
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end
      end
      TX_PAR: begin
        if (tx_full) begin
          tx_st_d = TX_STOP;
          tx_d    = 1'b1;
          tx_clr  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_full) begin
          tx_clr = 1'b1;
          if (tx_idx_q == IW'(STOP - 1)) begin
            tx_st_d  = TX_IDLE;
            tx_idx_d = '0;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_st_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // TX state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= TX_IDLE;
      tx_sh_q  <= '0;
      tx_idx_q <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_sh_q  <= tx_sh_d;
      tx_idx_q <= tx_idx_d;
      tx_par_q <= tx_par_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (tx_st_q == TX_IDLE);

  // ---------------- receiver ----------------
  logic            rx_s1_q, rx_s2_q, rx_s;
  rx_state_t       rx_st_q, rx_st_d;
  logic [DATA-1:0] rx_sh_q, rx_sh_d;
  logic [DATA-1:0] rx_data_q, rx_data_d;
  logic [IW-1:0]   rx_idx_q, rx_idx_d;
  logic            rx_pbad_q, rx_pbad_d;
  logic            rx_fbad_q, rx_fbad_d;
  logic            rx_vld_q, rx_vld_d;
  logic            rx_fe_q, rx_fe_d;
  logic            rx_pe_q, rx_pe_d;
  logic            rx_clr, rx_half, rx_full;

  assign rx_s = rx_s2_q;

  // two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  uart_bit_timer #(.CYCLES(CYCLES)) u_rx_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rx_clr),
    .half_o (rx_half),
    .full_o (rx_full)
  );

  // RX sequencing: realign at mid start bit, then sample every bit period
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_idx_d  = rx_idx_q;
    rx_pbad_d = rx_pbad_q;
    rx_fbad_d = rx_fbad_q;
    rx_vld_d  = 1'b0;
    rx_fe_d   = 1'b0;
    rx_pe_d   = 1'b0;
    rx_clr    = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_st_d = RX_START;
          rx_clr  = 1'b1;
        end
      end
      RX_START: begin
        if (rx_half) begin
          if (rx_s) begin
            rx_st_d = RX_IDLE;
          end else begin
            rx_st_d   = RX_DATA;
            rx_clr    = 1'b1;
            rx_idx_d  = '0;
            rx_pbad_d = 1'b0;
            rx_fbad_d = 1'b0;
          end
        end
      end
      RX_DATA: begin
        if (rx_full) begin
          rx_clr  = 1'b1;
          rx_sh_d = {rx_s, rx_sh_q[DATA-1:1]};
          if (rx_idx_q == IW'(DATA - 1)) begin
            rx_idx_d = '0;
            if (PARITY == PAR_NONE) rx_st_d = RX_STOP;
            else                    rx_st_d = RX_PAR;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (rx_full) begin
          rx_clr    = 1'b1;
          rx_pbad_d = rx_s ^ par_bit(PARITY, ^rx_sh_q);
          rx_st_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_full) begin
          rx_clr = 1'b1;
          if (!rx_s) rx_fbad_d = 1'b1;
          if (rx_idx_q == IW'(STOP - 1)) begin
            rx_idx_d = '0;
            if (rx_fbad_q || !rx_s) begin
              rx_fe_d = 1'b1;
              rx_st_d = RX_WAIT_HIGH;
            end else if (rx_pbad_q) begin
              rx_pe_d = 1'b1;
              rx_st_d = RX_IDLE;
            end else begin
              rx_vld_d  = 1'b1;
              rx_data_d = rx_sh_q;
              rx_st_d   = RX_IDLE;
            end
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // RX state, result and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q   <= RX_IDLE;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_idx_q  <= '0;
      rx_pbad_q <= 1'b0;
      rx_fbad_q <= 1'b0;
      rx_vld_q  <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_pe_q   <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_idx_q  <= rx_idx_d;
      rx_pbad_q <= rx_pbad_d;
      rx_fbad_q <= rx_fbad_d;
      rx_vld_q  <= rx_vld_d;
      rx_fe_q   <= rx_fe_d;
      rx_pe_q   <= rx_pe_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_vld_q;
  assign bus.rx_frame_err  = rx_fe_q;
  assign bus.rx_parity_err = rx_pe_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: 8N1, 8E2 loopback and 8O1 instances
// against a frame-list reference model.
module tb_uart_cfg;
  import uart_pkg::*;

  localparam int CYC = 10;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_if #(.DATA(8)) if_n1 ();
  uart_if #(.DATA(8)) if_e2 ();
  uart_if #(.DATA(8)) if_o1 ();

  assign if_e2.rx = if_e2.tx;

  uart_cfg #(
    .CLOCK(1000000), .BAUD(100000), .DATA(8),
    .PARITY(PAR_NONE), .STOP(1)
  ) u_n1 (.clk(clk), .rst(rst), .bus(if_n1.slave));

  uart_cfg #(
    .CLOCK(1000000), .BAUD(100000), .DATA(8),
    .PARITY(PAR_EVEN), .STOP(2)
  ) u_e2 (.clk(clk), .rst(rst), .bus(if_e2.slave));

  uart_cfg #(
    .CLOCK(1000000), .BAUD(100000), .DATA(8),
    .PARITY(PAR_ODD), .STOP(1)
  ) u_o1 (.clk(clk), .rst(rst), .bus(if_o1.slave));

  int checks = 0;
  int errors = 0;

  // pulse tallies per instance
  int n1_v, n1_f, n1_p, o1_v, o1_f, o1_p, e2_f, e2_p;
  logic [7:0] e2_got[$];

  always @(posedge clk) begin
    if (if_n1.rx_valid)      n1_v <= n1_v + 1;
    if (if_n1.rx_frame_err)  n1_f <= n1_f + 1;
    if (if_n1.rx_parity_err) n1_p <= n1_p + 1;
    if (if_o1.rx_valid)      o1_v <= o1_v + 1;
    if (if_o1.rx_frame_err)  o1_f <= o1_f + 1;
    if (if_o1.rx_parity_err) o1_p <= o1_p + 1;
    if (if_e2.rx_frame_err)  e2_f <= e2_f + 1;
    if (if_e2.rx_parity_err) e2_p <= e2_p + 1;
    if (if_e2.rx_valid)      e2_got.push_back(if_e2.rx_data);
  end

  // reference: line levels of one frame, one entry per bit period
  function automatic bitq_t frame(input int d, input int nd,
                                  input parity_t p, input int ns);
    bitq_t q;
    int ones;
    q.push_back(1'b0);
    for (int i = 0; i < nd; i++) q.push_back(bit'((d >> i) & 1));
    ones = $countones(d & ((1 << nd) - 1));
    if (p == PAR_EVEN)     q.push_back(bit'(ones % 2));
    else if (p == PAR_ODD) q.push_back(bit'((ones + 1) % 2));
    for (int i = 0; i < ns; i++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sel 0 drives the 8N1 line, sel 1 the 8O1 line
  task automatic drive_rx(input int sel, input bitq_t f);
    for (int i = 0; i < f.size() * CYC; i++) begin
      if (sel == 0) if_n1.rx = f[i / CYC];
      else          if_o1.rx = f[i / CYC];
      tick();
    end
    if (sel == 0) if_n1.rx = 1'b1;
    else          if_o1.rx = 1'b1;
  endtask

  // send one word on 8N1 and compare every clock of the line
  task automatic tx_n1(input logic [7:0] d, input string tag);
    bitq_t f;
    int w;
    f = frame(d, 8, PAR_NONE, 1);
    w = 0;
    while (!if_n1.tx_ready && w < 300) begin
      tick();
      w++;
    end
    chk({tag, "_rdy_pre"}, if_n1.tx_ready, 1);
    if_n1.tx_data  = d;
    if_n1.tx_valid = 1'b1;
    tick();
    if_n1.tx_valid = 1'b0;
    if_n1.tx_data  = ~d;
    for (int i = 0; i < f.size() * CYC; i++) begin
      chk({tag, "_line"}, if_n1.tx, f[i / CYC]);
      chk({tag, "_busy"}, if_n1.tx_ready, 0);
      tick();
    end
    chk({tag, "_rdy_end"}, if_n1.tx_ready, 1);
    chk({tag, "_idle"}, if_n1.tx, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bitq_t f;
    logic [7:0] d, r;
    logic [7:0] words[$];
    int v0, f0, p0, idx, cyc, last_hs;
    bit hs;

    if_n1.tx_data = '0; if_n1.tx_valid = 1'b0; if_n1.rx = 1'b1;
    if_e2.tx_data = '0; if_e2.tx_valid = 1'b0;
    if_o1.tx_data = '0; if_o1.tx_valid = 1'b0; if_o1.rx = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_tx", if_n1.tx, 1);
    chk("rst_rdy", if_n1.tx_ready, 1);
    chk("rst_rxd", if_n1.rx_data, 0);
    chk("rst_vld", if_n1.rx_valid, 0);
    chk("rst_fe", if_n1.rx_frame_err, 0);
    chk("rst_pe", if_n1.rx_parity_err, 0);
    chk("rst_e2tx", if_e2.tx, 1);

    // 8N1 transmit: fixed and random words
    tx_n1(8'hA5, "t1a5");
    tx_n1(8'($urandom), "t1rnd");

    // 8E2 loopback with tx_valid held
    words = '{8'h00, 8'hFF, 8'h3C};
    words.push_back(8'($urandom));
    words.push_back(8'($urandom));
    idx = 0; cyc = 0; last_hs = 0;
    if_e2.tx_valid = 1'b1;
    if_e2.tx_data  = words[0];
    while (idx < words.size() && cyc < 2000) begin
      hs = if_e2.tx_ready && if_e2.tx_valid;
      tick();
      cyc++;
      if (hs) begin
        if (idx > 0) chk("t2_hs_gap", cyc - last_hs, 121);
        last_hs = cyc;
        idx++;
        if (idx < words.size()) if_e2.tx_data = words[idx];
        else                    if_e2.tx_valid = 1'b0;
      end
    end
    chk("t2_all_sent", idx, words.size());
    tick(200);
    chk("t2_count", e2_got.size(), words.size());
    for (int i = 0; i < words.size() && i < e2_got.size(); i++)
      chk("t2_data", e2_got[i], words[i]);
    chk("t2_fe", e2_f, 0);
    chk("t2_pe", e2_p, 0);

    // 8O1: good frame, then wrong parity bits
    d = 8'($urandom);
    v0 = o1_v; f0 = o1_f; p0 = o1_p;
    drive_rx(1, frame(d, 8, PAR_ODD, 1));
    tick(20);
    chk("t3_good_vld", o1_v - v0, 1);
    chk("t3_good_data", if_o1.rx_data, d);
    chk("t3_good_pe", o1_p - p0, 0);
    f = frame(8'h01, 8, PAR_ODD, 1);
    f[9] = 1'b1;
    v0 = o1_v; f0 = o1_f; p0 = o1_p;
    drive_rx(1, f);
    tick(20);
    chk("t3_pe", o1_p - p0, 1);
    chk("t3_pe_vld", o1_v - v0, 0);
    chk("t3_pe_fe", o1_f - f0, 0);
    chk("t3_pe_hold", if_o1.rx_data, d);
    r = 8'($urandom);
    f = frame(r, 8, PAR_ODD, 1);
    f[9] = ~f[9];
    v0 = o1_v; p0 = o1_p;
    drive_rx(1, f);
    tick(20);
    chk("t3_rnd_pe", o1_p - p0, 1);
    chk("t3_rnd_vld", o1_v - v0, 0);

    // break on 8N1 rx
    v0 = n1_v; f0 = n1_f; p0 = n1_p;
    if_n1.rx = 1'b0;
    tick(20 * CYC);
    if_n1.rx = 1'b1;
    tick(20);
    chk("t4_fe", n1_f - f0, 1);
    chk("t4_vld", n1_v - v0, 0);
    chk("t4_pe", n1_p - p0, 0);
    v0 = n1_v;
    drive_rx(0, frame(8'h5A, 8, PAR_NONE, 1));
    tick(20);
    chk("t4_after_vld", n1_v - v0, 1);
    chk("t4_after_data", if_n1.rx_data, 8'h5A);

    // short glitch is rejected
    v0 = n1_v; f0 = n1_f; p0 = n1_p;
    if_n1.rx = 1'b0;
    tick(3);
    if_n1.rx = 1'b1;
    tick(30);
    chk("t5_vld", n1_v - v0, 0);
    chk("t5_fe", n1_f - f0, 0);
    chk("t5_pe", n1_p - p0, 0);
    chk("t5_idle", 32'(u_n1.rx_st_q), 32'(RX_IDLE));
    drive_rx(0, frame(8'hC3, 8, PAR_NONE, 1));
    tick(20);
    chk("t5_vld2", n1_v - v0, 1);
    chk("t5_data", if_n1.rx_data, 8'hC3);

    // reset during TX data bit 3 and RX data bit 4
    d = 8'($urandom);
    r = 8'($urandom);
    f = frame(r, 8, PAR_NONE, 1);
    v0 = n1_v; f0 = n1_f; p0 = n1_p;
    for (int j = -10; j < 45; j++) begin
      if_n1.rx = f[(j + 10) / CYC];
      if (j == 0) begin
        if_n1.tx_data  = d;
        if_n1.tx_valid = 1'b1;
      end else begin
        if_n1.tx_valid = 1'b0;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    chk("t6_tx", if_n1.tx, 1);
    chk("t6_rdy", if_n1.tx_ready, 1);
    rst = 1'b0;
    if_n1.rx = 1'b1;
    tick(150);
    chk("t6_vld", n1_v - v0, 0);
    chk("t6_fe", n1_f - f0, 0);
    chk("t6_pe", n1_p - p0, 0);
    tx_n1(8'($urandom), "t6tx");
    r = 8'($urandom);
    v0 = n1_v;
    drive_rx(0, frame(r, 8, PAR_NONE, 1));
    tick(20);
    chk("t6_rx_vld", n1_v - v0, 1);
    chk("t6_rx_data", if_n1.rx_data, r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
